// File: rtl/fetch_stage_pkg.sv
// Shared constants and state encoding for the instruction-fetch stage.
package fetch_stage_pkg;

  localparam int                DATA_WIDTH_DEF   = 32;
  localparam int                MEMORY_DEPTH_DEF = 32;
  localparam logic [31:0]       PC_RESET_DEF     = 32'h0040_0000;
  localparam logic [31:0]       NOP_INSTR        = 32'h0000_0000;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/fetch_stage_if_id_register.sv
// IF/ID pipeline register: loads on en, squash loads a NOP bubble, sync reset to NOP.
module if_id_register
  import fetch_stage_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic                  squash,
  input  logic [DATA_WIDTH-1:0] next_instruction,
  input  logic [DATA_WIDTH-1:0] next_pc_plus4,
  output logic [DATA_WIDTH-1:0] instruction,
  output logic [DATA_WIDTH-1:0] pc_plus4,
  output logic                  valid
);

  always_ff @(posedge clk) begin
    if (reset) begin
      instruction <= DATA_WIDTH'(NOP_INSTR);
      pc_plus4    <= '0;
      valid       <= 1'b0;
    end else if (en) begin
      if (squash) begin
        instruction <= DATA_WIDTH'(NOP_INSTR);
        pc_plus4    <= '0;
        valid       <= 1'b0;
      end else begin
        instruction <= next_instruction;
        pc_plus4    <= next_pc_plus4;
        valid       <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// MIPS fetch stage: PC, redirect/stall handling, program-window halt, IF/ID capture.
// Optional macro DELAY_SLOT_EN keeps the instruction fetched at a redirect as a valid delay slot.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter int                    DATA_WIDTH   = DATA_WIDTH_DEF,
  parameter int                    MEMORY_DEPTH = MEMORY_DEPTH_DEF,
  parameter logic [DATA_WIDTH-1:0] PC_RESET     = DATA_WIDTH'(PC_RESET_DEF)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  stall_i,
  input  logic                  redirect_i,
  input  logic [DATA_WIDTH-1:0] redirect_addr_i,
  input  logic [DATA_WIDTH-1:0] instruction_i,
  output logic [DATA_WIDTH-1:0] pc_o,
  output logic [DATA_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] if_id_instruction_o,
  output logic [DATA_WIDTH-1:0] if_id_pc_plus4_o,
  output logic                  if_id_valid_o,
  output logic                  halted_o
);

  localparam logic [DATA_WIDTH-1:0] WINDOW_BYTES = DATA_WIDTH'(4 * MEMORY_DEPTH);

  fetch_state_t          state;
  logic [DATA_WIDTH-1:0] pc;
  logic [DATA_WIDTH-1:0] pc_plus4;
  logic [DATA_WIDTH-1:0] offset;
  logic [DATA_WIDTH-1:0] redirect_pc;
  logic [DATA_WIDTH-1:0] redirect_offset;
  logic                  in_window;
  logic                  target_in_window;
  logic                  is_run;
  logic                  if_id_en;
  logic                  if_id_squash;

  // Unsigned offset compare covers both ends of the window, including wrap below PC_RESET.
  assign offset           = pc - PC_RESET;
  assign in_window        = offset < WINDOW_BYTES;
  assign pc_plus4         = pc + DATA_WIDTH'(4);
  assign redirect_pc      = {redirect_addr_i[DATA_WIDTH-1:2], 2'b00};
  assign redirect_offset  = redirect_pc - PC_RESET;
  assign target_in_window = redirect_offset < WINDOW_BYTES;
  assign is_run           = (state == RUN);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= RUN;
      pc    <= PC_RESET;
    end else begin
      case (state)
        RUN: begin
          if (redirect_i) begin
            pc <= redirect_pc;
          end else if (!stall_i) begin
            if (in_window) begin
              pc <= pc_plus4;
            end else begin
              state <= HALT;
            end
          end
        end
        HALT: begin
          // Out-of-window redirects are ignored so the PC stays parked.
          if (redirect_i && target_in_window) begin
            pc    <= redirect_pc;
            state <= RUN;
          end
        end
        default: state <= HALT;
      endcase
    end
  end

  assign if_id_en = redirect_i | ~stall_i;
`ifdef DELAY_SLOT_EN
  assign if_id_squash = ~is_run | ~in_window;
`else
  assign if_id_squash = ~is_run | ~in_window | redirect_i;
`endif

  if_id_register #(.DATA_WIDTH(DATA_WIDTH)) u_if_id (
    .clk              (clk),
    .reset            (reset),
    .en               (if_id_en),
    .squash           (if_id_squash),
    .next_instruction (instruction_i),
    .next_pc_plus4    (pc_plus4),
    .instruction      (if_id_instruction_o),
    .pc_plus4         (if_id_pc_plus4_o),
    .valid            (if_id_valid_o)
  );

  assign pc_o       = pc;
  assign mem_addr_o = offset;
  assign halted_o   = ~is_run;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: stimulus queues expected post-edge state, a monitor pops and compares.
module tb_fetch_stage;

  localparam logic [31:0] BASE = 32'h0040_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall_i = 1'b0;
  logic        redirect_i = 1'b0;
  logic [31:0] redirect_addr_i = '0;
  logic [31:0] instruction_i;
  logic [31:0] pc_o, mem_addr_o, if_id_instruction_o, if_id_pc_plus4_o;
  logic        if_id_valid_o, halted_o;

  always #5 clk = ~clk;

  fetch_stage #(.DATA_WIDTH(32), .MEMORY_DEPTH(32), .PC_RESET(BASE)) dut (
    .clk                 (clk),
    .reset               (reset),
    .stall_i             (stall_i),
    .redirect_i          (redirect_i),
    .redirect_addr_i     (redirect_addr_i),
    .instruction_i       (instruction_i),
    .pc_o                (pc_o),
    .mem_addr_o          (mem_addr_o),
    .if_id_instruction_o (if_id_instruction_o),
    .if_id_pc_plus4_o    (if_id_pc_plus4_o),
    .if_id_valid_o       (if_id_valid_o),
    .halted_o            (halted_o)
  );

  // ROM word i holds 0x20080001 + i; anything outside the window returns a poison pattern.
  function automatic logic [31:0] rom_word(input logic [31:0] idx);
    return 32'h2008_0001 + idx;
  endfunction

  assign instruction_i = (mem_addr_o < 32'd128) ? rom_word({27'd0, mem_addr_o[6:2]}) : 32'hBAD0_BAD0;

  typedef struct {
    string       name;
    logic [31:0] pc;
    logic [31:0] maddr;
    logic [31:0] instr;
    logic [31:0] pc4;
    logic        valid;
    logic        halted;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic step(input string name, input logic rst, input logic st, input logic rd,
                      input logic [31:0] ra, input logic [31:0] epc, input logic [31:0] ei,
                      input logic [31:0] ep4, input logic ev, input logic eh);
    exp_t e;
    @(negedge clk);
    reset = rst; stall_i = st; redirect_i = rd; redirect_addr_i = ra;
    e.name = name; e.pc = epc; e.maddr = epc - BASE; e.instr = ei;
    e.pc4 = ep4; e.valid = ev; e.halted = eh;
    q.push_back(e);
    @(posedge clk);
  endtask

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      checks++;
      if (pc_o !== e.pc || mem_addr_o !== e.maddr || if_id_instruction_o !== e.instr ||
          if_id_pc_plus4_o !== e.pc4 || if_id_valid_o !== e.valid || halted_o !== e.halted) begin
        errors++;
        $display("FAIL %s: got pc=%h addr=%h ins=%h pc4=%h v=%b h=%b, want pc=%h addr=%h ins=%h pc4=%h v=%b h=%b",
                 e.name, pc_o, mem_addr_o, if_id_instruction_o, if_id_pc_plus4_o, if_id_valid_o, halted_o,
                 e.pc, e.maddr, e.instr, e.pc4, e.valid, e.halted);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout, want finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] pb;
    step("reset",      1, 0, 0, 0, BASE,            32'h0,        32'h0,          0, 0);
    step("fetch0",     0, 0, 0, 0, 32'h0040_0004,   32'h2008_0001, 32'h0040_0004, 1, 0);
    step("fetch1",     0, 0, 0, 0, 32'h0040_0008,   32'h2008_0002, 32'h0040_0008, 1, 0);
    step("stall_a",    0, 1, 0, 0, 32'h0040_0008,   32'h2008_0002, 32'h0040_0008, 1, 0);
    step("stall_b",    0, 1, 0, 0, 32'h0040_0008,   32'h2008_0002, 32'h0040_0008, 1, 0);
    step("resume",     0, 0, 0, 0, 32'h0040_000C,   32'h2008_0003, 32'h0040_000C, 1, 0);
`ifdef DELAY_SLOT_EN
    step("redir_stall",0, 1, 1, 32'h0040_0013, 32'h0040_0010, 32'h2008_0004, 32'h0040_0010, 1, 0);
`else
    step("redir_stall",0, 1, 1, 32'h0040_0013, 32'h0040_0010, 32'h0,        32'h0,          0, 0);
`endif
    step("after_redir",0, 0, 0, 0, 32'h0040_0014,   32'h2008_0005, 32'h0040_0014, 1, 0);
    for (int k = 0; k < 27; k++) begin
      pb = 32'h0040_0014 + 32'(4 * k);
      step("run_to_end", 0, 0, 0, 0, pb + 4, rom_word((pb - BASE) >> 2), pb + 4, 1, 0);
    end
    step("halt_edge",  0, 0, 0, 0, 32'h0040_0080,   32'h0,        32'h0,          0, 1);
    step("halt_hold",  0, 0, 0, 0, 32'h0040_0080,   32'h0,        32'h0,          0, 1);
    step("halt_exit",  0, 0, 1, BASE, BASE,         32'h0,        32'h0,          0, 0);
    step("restart",    0, 0, 0, 0, 32'h0040_0004,   32'h2008_0001, 32'h0040_0004, 1, 0);
`ifdef DELAY_SLOT_EN
    step("redir_low",  0, 0, 1, 32'h0, 32'h0,        32'h2008_0002, 32'h0040_0008, 1, 0);
`else
    step("redir_low",  0, 0, 1, 32'h0, 32'h0,        32'h0,        32'h0,          0, 0);
`endif
    step("low_halt",   0, 0, 0, 0, 32'h0,           32'h0,        32'h0,          0, 1);
    step("halt_redir_out", 0, 0, 1, 32'h0040_0080, 32'h0, 32'h0,  32'h0,          0, 1);
    step("reset_in_halt", 1, 1, 1, BASE, BASE,      32'h0,        32'h0,          0, 0);
    step("post_reset", 0, 0, 0, 0, 32'h0040_0004,   32'h2008_0001, 32'h0040_0004, 1, 0);
    step("stall_pre",  0, 1, 0, 0, 32'h0040_0004,   32'h2008_0001, 32'h0040_0004, 1, 0);
    step("reset_in_stall", 1, 1, 0, 0, BASE,        32'h0,        32'h0,          0, 0);
    @(negedge clk);
    reset = 0;
    @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending, want 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
